// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU behind a valid/ready handshake.
// Single-cycle ops return a registered result one cycle after accept. MUL is an
// iterative shift-add that returns its result WIDTH+1 cycles after accept.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset_n      synchronous active-low reset
//   in_valid     operands and code present
//   in_ready     unit can accept on this cycle
//   ALU_control  4-bit operation code
//   a, b         operands (rs, rt/immediate)
//   out_valid    result/flags valid
//   out_ready    consumer takes the result this cycle
//   result       operation result
//   zero         result == 0
//   overflow     signed overflow, ADD/SUB only
//   illegal      an unsupported code was accepted
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {
        StIdle = 1'b0,
        StMul  = 1'b1
    } state_t;

    state_t           r_state, w_state_next;
    logic             r_out_valid, w_out_valid_next;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic             r_zero, w_zero_next;
    logic             r_overflow, w_overflow_next;
    logic             r_illegal, w_illegal_next;
    logic [WIDTH-1:0] r_mcand, w_mcand_next;
    logic [WIDTH-1:0] r_mplier, w_mplier_next;
    logic [WIDTH-1:0] r_acc, w_acc_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;

    logic [WIDTH-1:0] w_sum, w_diff, w_alu_res;
    logic             w_alu_ovf, w_alu_ill, w_slt, w_accept, w_is_mul;

    assign w_sum  = a + b;
    assign w_diff = a - b;
    // Differing signs decide SLT directly; otherwise a-b cannot overflow.
    assign w_slt  = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : w_diff[WIDTH-1];

    assign in_ready = (r_state == StIdle) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (ALU_control == OP_MUL);

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_ill = 1'b0;
        case (ALU_control)
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_NOR: w_alu_res = ~(a | b);
            default: w_alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next     = r_state;
        w_out_valid_next = r_out_valid;
        w_result_next    = r_result;
        w_zero_next      = r_zero;
        w_overflow_next  = r_overflow;
        w_illegal_next   = r_illegal;
        w_mcand_next     = r_mcand;
        w_mplier_next    = r_mplier;
        w_acc_next       = r_acc;
        w_cnt_next       = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (out_ready) begin
                    w_out_valid_next = 1'b0;
                end
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_mcand_next     = a;
                        w_mplier_next    = b;
                        w_acc_next       = '0;
                        w_cnt_next       = '0;
                        w_out_valid_next = 1'b0;
                        w_state_next     = StMul;
                    end else begin
                        w_result_next    = w_alu_res;
                        w_zero_next      = (w_alu_res == '0);
                        w_overflow_next  = w_alu_ovf;
                        w_illegal_next   = w_alu_ill;
                        w_out_valid_next = 1'b1;
                    end
                end
            end
            StMul: begin
                if (r_cnt == CNT_W'(WIDTH)) begin
                    w_result_next    = r_acc;
                    w_zero_next      = (r_acc == '0);
                    w_overflow_next  = 1'b0;
                    w_illegal_next   = 1'b0;
                    w_out_valid_next = 1'b1;
                    w_state_next     = StIdle;
                end else begin
                    // Shifting multiplicand/multiplier stands in for bit[counter] and <<counter.
                    if (r_mplier[0]) begin
                        w_acc_next = r_acc + r_mcand;
                    end
                    w_mcand_next  = r_mcand << 1;
                    w_mplier_next = r_mplier >> 1;
                    w_cnt_next    = r_cnt + 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= w_out_valid_next;
            r_result    <= w_result_next;
            r_zero      <= w_zero_next;
            r_overflow  <= w_overflow_next;
            r_illegal   <= w_illegal_next;
            r_mcand     <= w_mcand_next;
            r_mplier    <= w_mplier_next;
            r_acc       <= w_acc_next;
            r_cnt       <= w_cnt_next;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         o;
        logic         i;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   ctl;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero, overflow, illegal;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t q[$];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALU_control (ctl),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the operation table, using wide signed arithmetic.
    function automatic exp_t ref_model(input logic [3:0] c, input logic [W-1:0] x,
                                       input logic [W-1:0] y);
        exp_t e;
        longint s;
        longint unsigned p;
        e = '0;
        case (c)
            4'b0000: e.r = x & y;
            4'b0001: e.r = x | y;
            4'b0010: begin
                s = longint'($signed(x)) + longint'($signed(y));
                e.r = s[W-1:0];
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = longint'($signed(x)) - longint'($signed(y));
                e.r = s[W-1:0];
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1100: e.r = ~(x | y);
            4'b1000: begin
                p = {32'd0, x} * {32'd0, y};
                e.r = p[W-1:0];
            end
            default: e.i = 1'b1;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input logic o, input logic i);
        exp_t e;
        e.r = r;
        e.z = (r == '0);
        e.o = o;
        e.i = i;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                        input exp_t e, input bit rand_rdy, output int waits);
        in_valid = 1'b1;
        ctl      = c;
        a        = x;
        b        = y;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                break;
            end
            waits++;
            if (waits > 200) begin
                chk("accept_timeout", 64'(waits), 64'd0);
                break;
            end
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        ctl      = 4'($urandom);
    endtask

    // Monitor: pops on every output handshake and checks hold while stalled.
    initial begin
        exp_t cur, prev, e;
        bit   prev_hold;
        prev_hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {result, zero, overflow, illegal};
            if (!reset_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) chk("hold", {out_valid, cur}, {1'b1, prev});
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 64'(cur), 64'hDEAD);
                    end else begin
                        e = q.pop_front();
                        chk("result_flags", 64'(cur), 64'(e));
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev = cur;
            end
        end
    end

    logic [3:0] legal[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000};
    logic [W-1:0] special[5] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1};

    initial begin
        int w, n, busy;
        logic [3:0] c;
        logic [W-1:0] x, y;

        // Reset with in_valid asserted: nothing captured.
        reset_n = 1'b0; in_valid = 1'b1; ctl = 4'b0010; a = 32'd1; b = 32'd1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'({result, zero, overflow, illegal}), 64'd0);
        reset_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("rst_no_capture", 64'(out_valid), 64'd0);

        // Back-to-back single-cycle ops.
        send(4'b0000, 32'hF, 32'h5, mk(32'h5, 0, 0), 0, w);        chk("b2b_and", 64'(w), 0);
        send(4'b0001, 32'hF, 32'h5, mk(32'hF, 0, 0), 0, w);        chk("b2b_or", 64'(w), 0);
        send(4'b0010, 32'hF, 32'h5, mk(32'h14, 0, 0), 0, w);       chk("b2b_add", 64'(w), 0);
        send(4'b0110, 32'hF, 32'h5, mk(32'hA, 0, 0), 0, w);        chk("b2b_sub", 64'(w), 0);
        send(4'b0111, 32'hF, 32'h5, mk(32'h0, 0, 0), 0, w);        chk("b2b_slt", 64'(w), 0);
        send(4'b1100, 32'hF, 32'h5, mk(32'hFFFFFFF0, 0, 0), 0, w); chk("b2b_nor", 64'(w), 0);

        // Flag corners.
        send(4'b0010, 32'h7FFFFFFF, 32'h1, mk(32'h80000000, 1, 0), 0, w);
        send(4'b0110, 32'h5, 32'h5, mk(32'h0, 0, 0), 0, w);
        send(4'b0111, 32'h80000000, 32'h1, mk(32'h1, 0, 0), 0, w);
        send(4'b0101, 32'h1234, 32'h5678, mk(32'h0, 0, 1), 0, w);

        // MUL latency and busy window.
        send(4'b1000, 32'd7, 32'd6, mk(32'd42, 0, 0), 0, w);
        n = 0; busy = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
            if (in_ready) busy++;
        end
        chk("mul_latency", 64'(n), 64'(W + 1));
        chk("mul_busy", 64'(busy), 64'd0);
        send(4'b1000, 32'hFFFFFFFF, 32'd2, mk(32'hFFFFFFFE, 0, 0), 0, w);
        n = 0;
        while (n < 100 && !out_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;

        // Backpressure, then drain and accept on the same edge.
        send(4'b0010, 32'd3, 32'd4, mk(32'd7, 0, 0), 0, w);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_held", 64'({out_valid, result}), 64'({1'b1, 32'd7}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'b0110, 32'd9, 32'd4, mk(32'd5, 0, 0), 0, w);
        chk("bp_same_edge", 64'(w), 64'd0);
        chk("bp_new_result", 64'({out_valid, result}), 64'({1'b1, 32'd5}));

        // Reset mid-MUL aborts the multiply.
        @(posedge clk);
        #1;
        send(4'b1000, 32'd123, 32'd456, mk(32'd56088, 0, 0), 0, w);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        q.delete();
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_result", 64'(out_valid), 64'd0);
        send(4'b0010, 32'd10, 32'd20, mk(32'd30, 0, 0), 0, w);
        chk("post_abort_add", 64'({out_valid, result}), 64'({1'b1, 32'd30}));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 6)] : 4'($urandom);
            x = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
            send(c, x, y, ref_model(c, x, y), 1, w);
            if ($urandom_range(0, 4) == 0) begin
                out_ready = ($urandom_range(0, 1) != 0);
                @(posedge clk);
                #1;
            end
        end

        // Drain everything still owed.
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU: the consumer of the 4-bit ALU_control code produced by the ALU control decoder. Accepts operands plus code over a valid/ready handshake and returns a registered result with zero/overflow flags. Single-cycle ops complete in 1 cycle; MUL runs as a WIDTH-cycle iterative shift-add. Sits between the register-read stage and the writeback/branch logic of the multi-cycle datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
in_valid  input  1  operands and code present
in_ready  output  1  unit can accept on this cycle
ALU_control  input  4  operation code
a  input  WIDTH  operand A (rs)
b  input  WIDTH  operand B (rt or immediate)
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle
result  output  WIDTH  operation result
zero  output  1  result == 0 (beq support)
overflow  output  1  signed overflow, ADD/SUB only
illegal  output  1  unsupported code was accepted

Behaviour:
- Reset: when reset_n=0 at a rising edge: state=IDLE; out_valid, result, zero, overflow, illegal all 0; multiply accumulator/counter cleared. Reset mid-MUL aborts; no result produced.
- Codes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a-b); 0111 SLT (signed a<b -> 1, else 0, correct even when a-b overflows); 1100 NOR; 1000 MUL (low WIDTH bits of a*b, unsigned). Any other code: result=0, illegal=1, latency 1.
- Accept: transfer occurs when in_valid && in_ready at a rising edge; operands and code are captured then, so inputs may change afterwards.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept with simultaneous drain of the previous result is permitted (back-to-back throughput 1/cycle for single-cycle ops).
- FSM states: IDLE, MUL.
  IDLE: on accept of a non-MUL code, load result/flags, out_valid=1 next cycle (latency 1). On accept of MUL, capture operands, clear accumulator, counter=0, go to MUL; out_valid drops if it was drained that cycle.
  MUL: each cycle, if multiplier bit[counter]=1, accumulator += multiplicand<<counter (mod 2^WIDTH); counter++. After WIDTH iterations load result, flags, out_valid=1, return to IDLE. Result visible WIDTH+1 cycles after the accept edge. in_ready=0 throughout MUL.
- Output hold: while out_valid=1 and out_ready=0, result/zero/overflow/illegal are stable. out_valid falls on the edge where out_ready=1 unless a new accept occurs on that same edge, in which case the new single-cycle result replaces it.
- Flags: zero computed from the final result for every op (including illegal: zero=1). overflow=1 only for ADD when operands share a sign and the sum's sign differs, or for SUB when operand signs differ and the difference's sign differs from a; 0 for all other ops. illegal=0 for every legal code.
- Arithmetic wraps modulo 2^WIDTH; no exceptions raised.
- in_valid while in_ready=0: ignored, no capture.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, result=0, all flags 0, no capture; release -> in_ready=1.
- ALU ops, WIDTH=32, out_ready=1: a=0x0000000F, b=0x00000005 with codes 0000/0001/0010/0110/0111/1100 on consecutive cycles -> 0x5, 0xF, 0x14, 0xA, 0, 0xFFFFFFF0 on the following cycles; in_ready stays 1 throughout.
- Flags: ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1; SUB 5-5 -> 0, zero=1, overflow=0; SLT a=0x80000000, b=1 -> 1; code 0101 -> illegal=1, result=0, zero=1.
- MUL: a=7, b=6, code 1000 -> in_ready=0 for 32 cycles, out_valid=1 with result=42 exactly 33 cycles after the accept edge; a=0xFFFFFFFF, b=2 -> 0xFFFFFFFE.
- Backpressure: out_ready=0 after an ADD result -> result held stable and in_ready=0 for 5 cycles; raise out_ready with in_valid=1 (SUB 9-4) -> drain and accept on the same edge; 5 appears next cycle.
- Reset mid-MUL: assert reset_n=0 at iteration 10 -> state IDLE, out_valid=0; a new ADD afterwards completes normally with latency 1.
